// File: rtl/tlb_array_pkg.sv
// rtl/tlb_array_pkg.sv - TLB entry/response layouts, invtlb op codes and match helpers
package tlb_array_pkg;

   localparam int TLB_ENTRY_W = 89;
   localparam int PAGE_W      = 26;
   localparam int RSP_W       = 32;

   // Entry field offsets (MSB first: e, asid, g, ps, vppn, page0, page1)
   localparam int E_BIT       = 88;
   localparam int ASID_LSB    = 78;
   localparam int ASID_W      = 10;
   localparam int G_BIT       = 77;
   localparam int PS_LSB      = 71;
   localparam int PS_W        = 6;
   localparam int VPPN_LSB    = 52;
   localparam int VPPN_W      = 19;
   localparam int PAGE0_LSB   = 26;
   localparam int PAGE1_LSB   = 0;

   // Search response offsets: {ppn, ps, plv, mat, d, v}
   localparam int RSP_PPN_LSB = 12;
   localparam int RSP_PS_LSB  = 6;
   localparam int RSP_PLV_LSB = 4;
   localparam int RSP_MAT_LSB = 2;
   localparam int RSP_D_BIT   = 1;
   localparam int RSP_V_BIT   = 0;

   localparam logic [5:0] PS_4K = 6'd12;
   localparam logic [5:0] PS_2M = 6'd21;

   typedef enum logic [4:0] {
      INV_ALL0     = 5'd0,
      INV_ALL1     = 5'd1,
      INV_GLOBAL   = 5'd2,
      INV_NGLOBAL  = 5'd3,
      INV_ASID     = 5'd4,
      INV_ASID_VA  = 5'd5,
      INV_GASID_VA = 5'd6
   } invtlb_op_e;

   typedef struct packed {
      logic [19:0] ppn;
      logic [1:0]  plv;
      logic [1:0]  mat;
      logic        d;
      logic        v;
   } tlb_page_t;

   typedef struct packed {
      logic              e;
      logic [9:0]        asid;
      logic              g;
      logic [5:0]        ps;
      logic [18:0]       vppn;
      tlb_page_t         p0;
      tlb_page_t         p1;
   } tlb_entry_t;

   // Page-size aware VPPN compare; unsupported page sizes never match.
   function automatic logic vppn_eq(input logic [5:0] ps, input logic [18:0] e_vppn,
                                    input logic [18:0] vppn);
      if (ps == PS_4K)      return e_vppn == vppn;
      else if (ps == PS_2M) return e_vppn[18:9] == vppn[18:9];
      else                  return 1'b0;
   endfunction

   function automatic logic inv_hit(input tlb_entry_t ent, input logic [4:0] op,
                                    input logic [9:0] asid, input logic [18:0] vppn);
      logic asid_eq;
      logic va_eq;
      asid_eq = (ent.asid == asid);
      va_eq   = vppn_eq(ent.ps, ent.vppn, vppn);
      case (op)
         INV_ALL0, INV_ALL1: return 1'b1;
         INV_GLOBAL:         return ent.g;
         INV_NGLOBAL:        return !ent.g;
         INV_ASID:           return !ent.g && asid_eq;
         INV_ASID_VA:        return !ent.g && asid_eq && va_eq;
         INV_GASID_VA:       return (ent.g || asid_eq) && va_eq;
         default:            return 1'b0;
      endcase
   endfunction

   function automatic logic [RSP_W-1:0] pack_rsp(input tlb_page_t pg, input logic [5:0] ps);
      return {pg.ppn, ps, pg.plv, pg.mat, pg.d, pg.v};
   endfunction

endpackage

// File: rtl/tlb_array_if.sv
// rtl/tlb_array_if.sv - search, read, write and invtlb signals of the TLB array
interface tlb_array_if #(
   parameter int TLBNUM = 16
) ();
   import tlb_array_pkg::*;

   localparam int IDXW = $clog2(TLBNUM);

   logic [18:0]            s0_vppn;
   logic                   s0_va_bit12;
   logic [9:0]             s0_asid;
   logic                   s0_found;
   logic [IDXW-1:0]        s0_index;
   logic [RSP_W-1:0]       s0_rsp;

   logic [18:0]            s1_vppn;
   logic                   s1_va_bit12;
   logic [9:0]             s1_asid;
   logic                   s1_found;
   logic [IDXW-1:0]        s1_index;
   logic [RSP_W-1:0]       s1_rsp;

   logic                   we;
   logic [IDXW-1:0]        w_index;
   logic [TLB_ENTRY_W-1:0] w_entry;
   logic [IDXW-1:0]        r_index;
   logic [TLB_ENTRY_W-1:0] r_entry;

   logic                   invtlb_valid;
   logic [4:0]             invtlb_op;
   logic [9:0]             invtlb_asid;
   logic [18:0]            invtlb_vppn;

   logic [IDXW-1:0]        fill_index;

   modport slave (
      input  s0_vppn, s0_va_bit12, s0_asid,
      output s0_found, s0_index, s0_rsp,
      input  s1_vppn, s1_va_bit12, s1_asid,
      output s1_found, s1_index, s1_rsp,
      input  we, w_index, w_entry, r_index,
      output r_entry,
      input  invtlb_valid, invtlb_op, invtlb_asid, invtlb_vppn,
      output fill_index
   );

   modport master (
      output s0_vppn, s0_va_bit12, s0_asid,
      input  s0_found, s0_index, s0_rsp,
      output s1_vppn, s1_va_bit12, s1_asid,
      input  s1_found, s1_index, s1_rsp,
      output we, w_index, w_entry, r_index,
      input  r_entry,
      output invtlb_valid, invtlb_op, invtlb_asid, invtlb_vppn,
      input  fill_index
   );

endinterface

// File: rtl/tlb_array_match.sv
// rtl/tlb_array_match.sv - one combinational search port: match, priority encode, odd-page mux
module tlb_match
   import tlb_array_pkg::*;
#(
   parameter int TLBNUM = 16,
   localparam int IDXW  = $clog2(TLBNUM)
) (
   input  tlb_entry_t [TLBNUM-1:0] entries,
   input  logic [18:0]             vppn,
   input  logic                    va_bit12,
   input  logic [9:0]              asid,
   output logic                    found,
   output logic [IDXW-1:0]         index,
   output logic [RSP_W-1:0]        rsp
);

   tlb_entry_t hit;
   tlb_page_t  pg;
   logic       odd;

   always_comb begin
      found = 1'b0;
      index = '0;
      hit   = '0;
      pg    = '0;
      odd   = 1'b0;
      rsp   = '0;
      // Scan downward so the lowest matching index is the one left standing.
      for (int i = TLBNUM - 1; i >= 0; i--) begin
         if (entries[i].e && (entries[i].g || entries[i].asid == asid) &&
             vppn_eq(entries[i].ps, entries[i].vppn, vppn)) begin
            found = 1'b1;
            index = IDXW'(i);
            hit   = entries[i];
         end
      end
      if (found) begin
         odd = (hit.ps == PS_4K) ? va_bit12 : vppn[8];
         pg  = odd ? hit.p1 : hit.p0;
         rsp = pack_rsp(pg, hit.ps);
      end
   end

endmodule

// File: rtl/tlb_array.sv
// rtl/tlb_array.sv - TLB entry storage with two search ports, read/write, invtlb and fill index
module tlb_array
   import tlb_array_pkg::*;
#(
   parameter int TLBNUM = 16
) (
   input  logic        clk,
   input  logic        resetn,
   tlb_array_if.slave  bus
);

   localparam int IDXW = $clog2(TLBNUM);

   tlb_entry_t [TLBNUM-1:0] entries_q;
   tlb_entry_t [TLBNUM-1:0] entries_d;
   logic [IDXW-1:0]         fill_index_q;
   logic [IDXW-1:0]         fill_index_d;

   // Invalidation is folded in before the write so a same-cycle write lands intact.
   always_comb begin
      entries_d = entries_q;
      if (bus.invtlb_valid) begin
         for (int i = 0; i < TLBNUM; i++) begin
            if (inv_hit(entries_q[i], bus.invtlb_op, bus.invtlb_asid, bus.invtlb_vppn)) begin
               entries_d[i].e = 1'b0;
            end
         end
      end
      if (bus.we) begin
         entries_d[bus.w_index] = tlb_entry_t'(bus.w_entry);
      end
      fill_index_d = fill_index_q + IDXW'(1);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         entries_q    <= '0;
         fill_index_q <= '0;
      end else begin
         entries_q    <= entries_d;
         fill_index_q <= fill_index_d;
      end
   end

   assign bus.r_entry    = entries_q[bus.r_index];
   assign bus.fill_index = fill_index_q;

   tlb_match #(.TLBNUM(TLBNUM)) u_match_s0 (
      .entries   (entries_q),
      .vppn      (bus.s0_vppn),
      .va_bit12  (bus.s0_va_bit12),
      .asid      (bus.s0_asid),
      .found     (bus.s0_found),
      .index     (bus.s0_index),
      .rsp       (bus.s0_rsp)
   );

   tlb_match #(.TLBNUM(TLBNUM)) u_match_s1 (
      .entries   (entries_q),
      .vppn      (bus.s1_vppn),
      .va_bit12  (bus.s1_va_bit12),
      .asid      (bus.s1_asid),
      .found     (bus.s1_found),
      .index     (bus.s1_index),
      .rsp       (bus.s1_rsp)
   );

endmodule
